// File: rtl/half_adder_unit.sv
// One-bit half adder: combinational sum/carry plus a registered observation
// stage with a saturating count of carry events.
module half_adder_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic [CNT_W-1:0] carry_count,
  output logic             carry_sat
);

  logic             sum_d;
  logic             cout_d;
  logic [CNT_W-1:0] carry_count_d;
  logic [CNT_W-1:0] carry_count_q;
  logic             carry_sat_d;
  logic             carry_sat_q;

  always_comb begin
    sum  = a ^ b;
    cout = a & b;
  end

  always_comb begin
    sum_d         = sum;
    cout_d        = cout;
    carry_count_d = carry_count_q;
    if (cout && (carry_count_q != '1)) begin
      carry_count_d = carry_count_q + CNT_W'(1);
    end
    // Sticky: once all-ones is reached the flag holds until reset.
    carry_sat_d = carry_sat_q | (carry_count_d == '1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q         <= 1'b0;
      cout_q        <= 1'b0;
      carry_count_q <= '0;
      carry_sat_q   <= 1'b0;
    end else begin
      sum_q         <= sum_d;
      cout_q        <= cout_d;
      carry_count_q <= carry_count_d;
      carry_sat_q   <= carry_sat_d;
    end
  end

  assign carry_count = carry_count_q;
  assign carry_sat   = carry_sat_q;

endmodule

// File: tb/tb_half_adder_unit.sv
// Self-checking bench for half_adder_unit: directed cases plus random stimulus
// against an arithmetic reference model (default width and a 2-bit counter).
module tb_half_adder_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        a, b;
  logic        sum, cout, sum_q, cout_q;
  logic [15:0] carry_count;
  logic        carry_sat;
  logic        sum2, cout2, sum_q2, cout_q2;
  logic [1:0]  carry_count2;
  logic        carry_sat2;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: registered bits and the total number of carry edges.
  logic m_sum_q, m_cout_q;
  int   m_carries;

  always #5 clk = ~clk;

  half_adder_unit u_dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .sum(sum), .cout(cout), .sum_q(sum_q), .cout_q(cout_q),
    .carry_count(carry_count), .carry_sat(carry_sat)
  );

  half_adder_unit #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .sum(sum2), .cout(cout2), .sum_q(sum_q2), .cout_q(cout_q2),
    .carry_count(carry_count2), .carry_sat(carry_sat2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb();
    logic [1:0] r;
    r = {1'b0, a} + {1'b0, b};
    chk("sum", {31'd0, sum}, {31'd0, r[0]});
    chk("cout", {31'd0, cout}, {31'd0, r[1]});
    chk("sum_w2", {31'd0, sum2}, {31'd0, r[0]});
    chk("cout_w2", {31'd0, cout2}, {31'd0, r[1]});
  endtask

  task automatic set_in(input logic r, input logic x, input logic y);
    reset = r;
    a     = x;
    b     = y;
    #1 chk_comb();
  endtask

  // Advance one rising edge, update the model from what the DUT sampled, check.
  task automatic step();
    logic [1:0] r;
    int         sat16, sat2;
    @(posedge clk);
    r = {1'b0, a} + {1'b0, b};
    if (reset) begin
      m_sum_q   = 1'b0;
      m_cout_q  = 1'b0;
      m_carries = 0;
    end else begin
      m_sum_q   = r[0];
      m_cout_q  = r[1];
      m_carries = m_carries + int'(r[1]);
    end
    sat16 = (m_carries > 65535) ? 65535 : m_carries;
    sat2  = (m_carries > 3) ? 3 : m_carries;
    #1;
    chk("sum_q", {31'd0, sum_q}, {31'd0, m_sum_q});
    chk("cout_q", {31'd0, cout_q}, {31'd0, m_cout_q});
    chk("carry_count", {16'd0, carry_count}, sat16);
    chk("carry_sat", {31'd0, carry_sat}, (sat16 == 65535) ? 32'd1 : 32'd0);
    chk("sum_q_w2", {31'd0, sum_q2}, {31'd0, m_sum_q});
    chk("cout_q_w2", {31'd0, cout_q2}, {31'd0, m_cout_q});
    chk("carry_count_w2", {30'd0, carry_count2}, sat2);
    chk("carry_sat_w2", {31'd0, carry_sat2}, (sat2 == 3) ? 32'd1 : 32'd0);
  endtask

  initial begin
    m_sum_q   = 1'b0;
    m_cout_q  = 1'b0;
    m_carries = 0;

    // Exhaustive combinational path while reset is held, before any edge.
    set_in(1'b1, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b1);
    set_in(1'b1, 1'b1, 1'b0);
    set_in(1'b1, 1'b1, 1'b1);
    step();
    chk("reset_count", {16'd0, carry_count}, 32'd0);

    // Registered path: one carry cycle then a sum-only cycle.
    @(negedge clk); set_in(1'b0, 1'b1, 1'b1);
    step();
    chk("reg_cout_q_1", {31'd0, cout_q}, 32'd1);
    @(negedge clk); set_in(1'b0, 1'b1, 1'b0);
    step();
    chk("reg_sum_q_2", {31'd0, sum_q}, 32'd1);
    chk("reg_cout_q_2", {31'd0, cout_q}, 32'd0);

    // Counter and saturation: reset, then six carry edges.
    @(negedge clk); set_in(1'b1, 1'b0, 1'b0);
    step();
    @(negedge clk); set_in(1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("sat_count_w2", {30'd0, carry_count2}, (i >= 3) ? 32'd3 : i);
      chk("sat_flag_w2", {31'd0, carry_sat2}, (i >= 3) ? 32'd1 : 32'd0);
      if (i == 5) begin
        chk("count_5", {16'd0, carry_count}, 32'd5);
        chk("sat_5", {31'd0, carry_sat}, 32'd0);
      end
    end

    // Reset mid-count wins over a simultaneous carry.
    @(negedge clk); set_in(1'b1, 1'b0, 1'b0);
    step();
    @(negedge clk); set_in(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("mid_count_4", {16'd0, carry_count}, 32'd4);
    @(negedge clk); set_in(1'b1, 1'b1, 1'b1);
    step();
    chk("mid_rst_count", {16'd0, carry_count}, 32'd0);
    chk("mid_rst_sum_q", {31'd0, sum_q}, 32'd0);
    chk("mid_rst_cout_q", {31'd0, cout_q}, 32'd0);
    chk("mid_rst_cout", {31'd0, cout}, 32'd1);

    // Random inputs changing on both edges, occasional reset.
    @(negedge clk); set_in(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      set_in(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom));
      step();
      set_in(reset, 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
